// File: rtl/acc_mem_responder_if.sv
// -----------------------------------------------------------------------------
// acc_mem_responder_if
// Accelerator memory bus plus the start/finish run handshake.
//   addr   : accelerator word address
//   dataR  : read data back to the accelerator (1-cycle latency)
//   dataW  : write data from the accelerator
//   en, we : access request, 1 = write / 0 = read
//   start  : run request to the accelerator
//   finish : accelerator completion
// master = accelerator side, slave = memory responder side.
// -----------------------------------------------------------------------------
interface acc_mem_responder_if;
   logic [15:0] addr;
   logic [31:0] dataR;
   logic [31:0] dataW;
   logic        en;
   logic        we;
   logic        start;
   logic        finish;

   modport master (
      output addr, dataW, en, we, finish,
      input  dataR, start
   );

   modport slave (
      input  addr, dataW, en, we, finish,
      output dataR, start
   );
endinterface

// File: rtl/acc_mem_responder.sv
// -----------------------------------------------------------------------------
// acc_mem_responder
// Memory side of the accelerator: a word-addressed image memory serving
// accelerator reads/writes with 1-cycle read latency, the host end of the
// start/finish handshake, a host load/dump port and per-run statistics.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   acc (slave)           : addr/dataR/dataW/en/we + start/finish
//   go, clr               : host pulses, begin a run / leave DONE
//   busy, done, err       : RUN state, DONE state, sticky out-of-range flag
//   host_we/addr/wdata    : host write port (IDLE and DONE only)
//   host_rdata            : host read data, 1-cycle latency, any state
//   rd_cnt/wr_cnt/cyc_cnt : saturating statistics for the current run
// -----------------------------------------------------------------------------
module acc_mem_responder #(
   parameter int DEPTH = 32768,
   parameter int CNT_W = 24
) (
   input  logic               clk,
   input  logic               reset,
   acc_mem_responder_if.slave acc,
   input  logic               go,
   input  logic               clr,
   output logic               busy,
   output logic               done,
   output logic               err,
   input  logic               host_we,
   input  logic [15:0]        host_addr,
   input  logic [31:0]        host_wdata,
   output logic [31:0]        host_rdata,
   output logic [CNT_W-1:0]   rd_cnt,
   output logic [CNT_W-1:0]   wr_cnt,
   output logic [CNT_W-1:0]   cyc_cnt
);
   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] mem [DEPTH];

   logic          acc_ok;
   logic          host_ok;
   logic          acc_rd;
   logic          acc_wr;
   logic [AW-1:0] acc_idx;
   logic [AW-1:0] host_idx;

   // Range checks use a 17-bit compare so DEPTH up to 65536 stays exact.
   assign acc_ok   = ({1'b0, acc.addr} < DEPTH_L);
   assign host_ok  = ({1'b0, host_addr} < DEPTH_L);
   assign acc_rd   = acc.en & ~acc.we;
   assign acc_wr   = acc.en & acc.we;
   assign acc_idx  = acc.addr[AW-1:0];
   assign host_idx = host_addr[AW-1:0];

   // NOTE: the image memory has no reset so it maps onto RAM and keeps its
   // contents across a reset pulse.
   // The host write comes second, so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (acc_wr && acc_ok)
         mem[acc_idx] <= acc.dataW;
      if (host_we && host_ok && state != RUN)
         mem[host_idx] <= host_wdata;
   end

   // Read ports sample the memory before this edge's writes land, so a read
   // one cycle after a write already sees the new word without any bypass.
   // NOTE: sequential state uses non-blocking assignments so every register
   // updates from pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc.dataR  <= '0;
         host_rdata <= '0;
      end else begin
         if (acc_rd)
            acc.dataR <= acc_ok ? mem[acc_idx] : '0;
         host_rdata <= host_ok ? mem[host_idx] : '0;
      end
   end

   // Run sequencer with registered start/busy/done and run statistics.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         acc.start <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         rd_cnt    <= '0;
         wr_cnt    <= '0;
         cyc_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               // go beats clr: clr is only honoured in DONE.
               if (go) begin
                  state     <= RUN;
                  acc.start <= 1'b1;
                  busy      <= 1'b1;
                  err       <= 1'b0;
                  rd_cnt    <= '0;
                  wr_cnt    <= '0;
                  cyc_cnt   <= '0;
               end
            end
            RUN: begin
               if (acc_rd && rd_cnt != '1)
                  rd_cnt <= rd_cnt + CNT_W'(1);
               if (acc_wr && wr_cnt != '1)
                  wr_cnt <= wr_cnt + CNT_W'(1);
               if (cyc_cnt != '1)
                  cyc_cnt <= cyc_cnt + CNT_W'(1);
               if (acc.finish) begin
                  state     <= DONE;
                  acc.start <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end
            end
            DONE: begin
               if (clr) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               acc.start <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
         // Placed after the go clear: an out-of-range access on the go edge
         // still leaves err set for the new run.
         if (acc.en && !acc_ok)
            err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_acc_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_acc_mem_responder
// Self-checking bench: a directed vector table, hand-written multi-cycle
// sequences and randomized traffic, all compared every cycle against a
// behavioural model built from an address->word map and per-run tallies.
// -----------------------------------------------------------------------------
module tb_acc_mem_responder;
   localparam int DEPTH = 32768;
   localparam int CNT_W = 5;
   localparam int CMAX  = (1 << CNT_W) - 1;
   localparam bit O = 1'b0;
   localparam bit I = 1'b1;

   typedef struct {
      bit          go, clr, en, we, fin, hwe;
      logic [15:0] addr, haddr;
      logic [31:0] dw, hwd;
      bit          chk_dr;
      logic [31:0] exp_dr;
      bit          chk_hr;
      logic [31:0] exp_hr;
      bit          chk_err, exp_err;
      bit          chk_cnt;
      int          exp_rd, exp_wr;
   } vec_t;

   logic             clk;
   logic             reset;
   logic             go, clr, host_we;
   logic [15:0]      host_addr;
   logic [31:0]      host_wdata, host_rdata;
   logic             busy, done, err;
   logic [CNT_W-1:0] rd_cnt, wr_cnt, cyc_cnt;

   acc_mem_responder_if bus ();

   acc_mem_responder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .acc        (bus),
      .go         (go),
      .clr        (clr),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_rdata (host_rdata),
      .rd_cnt     (rd_cnt),
      .wr_cnt     (wr_cnt),
      .cyc_cnt    (cyc_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: run phase flags, word map, tallies.
   bit          m_run, m_done, m_err;
   int          m_rd, m_wr, m_cyc;
   logic [31:0] m_mem [int];
   logic [31:0] m_dr, m_hr;
   bit          m_dr_known, m_hr_known;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int x);
      return (x > CMAX) ? CMAX : x;
   endfunction

   task automatic model_reset();
      m_run = 0; m_done = 0; m_err = 0;
      m_rd = 0; m_wr = 0; m_cyc = 0;
      m_dr = '0; m_hr = '0; m_dr_known = 1; m_hr_known = 1;
   endtask

   // One rising edge: reads see the map as it was before this edge's writes.
   task automatic model_edge();
      bit was_run  = m_run;
      bit was_idle = !m_run && !m_done;
      int a = int'(bus.addr);
      int h = int'(host_addr);
      if (bus.en && !bus.we) begin
         if (a >= DEPTH) begin
            m_dr = '0; m_dr_known = 1;
         end else if (m_mem.exists(a)) begin
            m_dr = m_mem[a]; m_dr_known = 1;
         end else
            m_dr_known = 0;
      end
      if (h >= DEPTH) begin
         m_hr = '0; m_hr_known = 1;
      end else if (m_mem.exists(h)) begin
         m_hr = m_mem[h]; m_hr_known = 1;
      end else
         m_hr_known = 0;
      if (bus.en && bus.we && a < DEPTH) m_mem[a] = bus.dataW;
      if (host_we && !was_run && h < DEPTH) m_mem[h] = host_wdata;
      if (was_idle && go) m_err = 0;
      if (bus.en && a >= DEPTH) m_err = 1;
      if (was_run) begin
         if (bus.en && !bus.we) m_rd = sat(m_rd + 1);
         if (bus.en && bus.we)  m_wr = sat(m_wr + 1);
         m_cyc = sat(m_cyc + 1);
      end
      if (was_idle && go) begin
         m_rd = 0; m_wr = 0; m_cyc = 0; m_run = 1;
      end else if (was_run && bus.finish) begin
         m_run = 0; m_done = 1;
      end else if (m_done && clr)
         m_done = 0;
   endtask

   task automatic compare_all();
      check("start",   32'(bus.start), 32'(m_run));
      check("busy",    32'(busy),      32'(m_run));
      check("done",    32'(done),      32'(m_done));
      check("err",     32'(err),       32'(m_err));
      check("rd_cnt",  32'(rd_cnt),    32'(m_rd));
      check("wr_cnt",  32'(wr_cnt),    32'(m_wr));
      check("cyc_cnt", 32'(cyc_cnt),   32'(m_cyc));
      if (m_dr_known) check("dataR", bus.dataR, m_dr);
      if (m_hr_known) check("host_rdata", host_rdata, m_hr);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   function automatic vec_t idle_v();
      vec_t v;
      v = '{O,O,O,O,O,O, 16'd0,16'd0, 32'h0,32'h0, O,32'h0, O,32'h0, O,O, O,0,0};
      return v;
   endfunction

   task automatic drive(input vec_t v);
      go         = v.go;
      clr        = v.clr;
      bus.en     = v.en;
      bus.we     = v.we;
      bus.finish = v.fin;
      bus.addr   = v.addr;
      bus.dataW  = v.dw;
      host_we    = v.hwe;
      host_addr  = v.haddr;
      host_wdata = v.hwd;
   endtask

   function automatic logic [15:0] pick_addr();
      case ($urandom_range(0, 9))
         0:       return 16'hFFFF;
         1:       return 16'd32768;
         2:       return 16'd32767;
         3:       return 16'd25432;
         default: return 16'($urandom_range(0, 15));
      endcase
   endfunction

   localparam int NV = 21;
   vec_t vec [NV];
   vec_t v;

   initial begin
      // go clr en we fin hwe | addr haddr | dw hwd | chk_dr exp_dr | chk_hr exp_hr | chk_err exp_err | chk_cnt rd wr
      vec[0]  = '{O,O,O,O,O,I, 16'd0,     16'd0,     32'h0,        32'h04030201, O,32'h0,        O,32'h0,        O,O, O,0,0};
      vec[1]  = '{O,O,O,O,O,I, 16'd0,     16'd88,    32'h0,        32'hAABBCCDD, O,32'h0,        O,32'h0,        O,O, O,0,0};
      vec[2]  = '{O,O,O,O,O,I, 16'd0,     16'd32767, 32'h0,        32'h7FFF0000, O,32'h0,        O,32'h0,        O,O, O,0,0};
      vec[3]  = '{O,O,O,O,O,O, 16'd0,     16'd0,     32'h0,        32'h0,        O,32'h0,        I,32'h04030201, O,O, O,0,0};
      vec[4]  = '{O,O,O,O,O,O, 16'd0,     16'd88,    32'h0,        32'h0,        O,32'h0,        I,32'hAABBCCDD, O,O, O,0,0};
      vec[5]  = '{I,O,O,O,O,O, 16'd0,     16'd0,     32'h0,        32'h0,        O,32'h0,        O,32'h0,        I,O, I,0,0};
      vec[6]  = '{O,O,I,O,O,O, 16'd0,     16'd0,     32'h0,        32'h0,        I,32'h04030201, O,32'h0,        O,O, O,0,0};
      vec[7]  = '{O,O,I,O,O,O, 16'd88,    16'd0,     32'h0,        32'h0,        I,32'hAABBCCDD, O,32'h0,        O,O, O,0,0};
      vec[8]  = '{O,O,O,O,O,O, 16'd0,     16'd0,     32'h0,        32'h0,        I,32'hAABBCCDD, O,32'h0,        O,O, I,2,0};
      vec[9]  = '{O,O,I,I,O,O, 16'd25432, 16'd0,     32'h11223344, 32'h0,        I,32'hAABBCCDD, O,32'h0,        O,O, O,0,0};
      vec[10] = '{O,O,I,O,O,O, 16'd25432, 16'd0,     32'h0,        32'h0,        I,32'h11223344, O,32'h0,        O,O, I,3,1};
      vec[11] = '{O,O,O,O,O,I, 16'd0,     16'd25432, 32'h0,        32'h0,        O,32'h0,        O,32'h0,        O,O, O,0,0};
      vec[12] = '{O,O,O,O,O,O, 16'd0,     16'd25432, 32'h0,        32'h0,        O,32'h0,        I,32'h11223344, O,O, O,0,0};
      vec[13] = '{O,O,I,O,O,O, 16'hFFFF,  16'd0,     32'h0,        32'h0,        I,32'h0,        O,32'h0,        I,I, I,4,1};
      vec[14] = '{O,O,I,I,O,O, 16'hFFFF,  16'd0,     32'hDEADBEEF, 32'h0,        I,32'h0,        O,32'h0,        I,I, I,4,2};
      vec[15] = '{O,O,O,O,O,O, 16'd0,     16'd32767, 32'h0,        32'h0,        O,32'h0,        I,32'h7FFF0000, I,I, O,0,0};
      vec[16] = '{O,O,O,O,I,O, 16'd0,     16'd0,     32'h0,        32'h0,        O,32'h0,        O,32'h0,        I,I, O,0,0};
      vec[17] = '{O,I,O,O,O,O, 16'd0,     16'd0,     32'h0,        32'h0,        O,32'h0,        O,32'h0,        I,I, O,0,0};
      vec[18] = '{I,O,O,O,O,O, 16'd0,     16'd0,     32'h0,        32'h0,        O,32'h0,        O,32'h0,        I,O, I,0,0};
      vec[19] = '{O,O,O,O,I,O, 16'd0,     16'd0,     32'h0,        32'h0,        O,32'h0,        O,32'h0,        O,O, O,0,0};
      vec[20] = '{O,I,O,O,O,O, 16'd0,     16'd0,     32'h0,        32'h0,        O,32'h0,        O,32'h0,        O,O, O,0,0};

      // Reset state.
      drive(idle_v());
      reset = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(negedge clk);
      reset = 1'b1;

      // Directed table: preload, read latency, write/read-back, out of range.
      for (int i = 0; i < NV; i++) begin
         drive(vec[i]);
         step();
         if (vec[i].chk_dr)  check($sformatf("vec%0d dataR", i), bus.dataR, vec[i].exp_dr);
         if (vec[i].chk_hr)  check($sformatf("vec%0d host_rdata", i), host_rdata, vec[i].exp_hr);
         if (vec[i].chk_err) check($sformatf("vec%0d err", i), 32'(err), 32'(vec[i].exp_err));
         if (vec[i].chk_cnt) begin
            check($sformatf("vec%0d rd_cnt", i), 32'(rd_cnt), 32'(vec[i].exp_rd));
            check($sformatf("vec%0d wr_cnt", i), 32'(wr_cnt), 32'(vec[i].exp_wr));
         end
      end

      // Handshake: 10 RUN cycles, the last one sampling finish.
      v = idle_v(); v.go = I; drive(v); step();
      check("hs start", 32'(bus.start), 32'd1);
      check("hs busy",  32'(busy),      32'd1);
      drive(idle_v());
      for (int i = 0; i < 9; i++) step();
      v = idle_v(); v.fin = I; drive(v); step();
      check("hs start drop", 32'(bus.start), 32'd0);
      check("hs done",       32'(done),      32'd1);
      check("hs cyc_cnt",    32'(cyc_cnt),   32'd10);
      v = idle_v(); v.go = I; drive(v); step();
      check("go in DONE done", 32'(done), 32'd1);
      check("go in DONE busy", 32'(busy), 32'd0);
      v = idle_v(); v.clr = I; drive(v); step();
      check("clr done", 32'(done), 32'd0);
      v = idle_v(); v.go = I; v.clr = I; drive(v); step();
      check("go+clr busy", 32'(busy), 32'd1);
      v = idle_v(); v.en = I; v.we = I; v.addr = 16'd5; v.dw = 32'hCAFEF00D; v.fin = I;
      drive(v); step();
      check("fin+wr done",   32'(done),   32'd1);
      check("fin+wr wr_cnt", 32'(wr_cnt), 32'd1);
      v = idle_v(); v.haddr = 16'd5; drive(v); step();
      check("fin+wr data", host_rdata, 32'hCAFEF00D);
      v = idle_v(); v.clr = I; drive(v); step();

      // Counter saturation: 40 reads in a 40-cycle run.
      v = idle_v(); v.go = I; drive(v); step();
      v = idle_v(); v.en = I; drive(v);
      for (int i = 0; i < 40; i++) step();
      check("sat rd_cnt",  32'(rd_cnt),  CMAX);
      check("sat cyc_cnt", 32'(cyc_cnt), CMAX);
      check("sat dataR",   bus.dataR,    32'h04030201);

      // Asynchronous reset mid-run, no clock edge in between.
      drive(idle_v());
      #2;
      reset = 1'b0;
      #1;
      check("arst start", 32'(bus.start), 32'd0);
      check("arst busy",  32'(busy),      32'd0);
      model_reset();
      compare_all();
      @(negedge clk);
      reset = 1'b1;
      v = idle_v(); v.haddr = 16'd0; drive(v); step();
      check("arst keep 0", host_rdata, 32'h04030201);
      v = idle_v(); v.haddr = 16'd88; drive(v); step();
      check("arst keep 88", host_rdata, 32'hAABBCCDD);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         v = idle_v();
         v.go    = ($urandom_range(0, 5) == 0);
         v.clr   = ($urandom_range(0, 3) == 0);
         v.fin   = ($urandom_range(0, 11) == 0);
         v.en    = ($urandom_range(0, 1) == 1);
         v.we    = ($urandom_range(0, 1) == 1);
         v.hwe   = ($urandom_range(0, 2) == 0);
         v.addr  = pick_addr();
         v.haddr = pick_addr();
         v.dw    = $urandom;
         v.hwd   = $urandom;
         drive(v);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
